inst_fetch_ctrl: RTL

Instruction-fetch sequencer for the single-issue RISC-V core. It owns the program counter, drives the address of the combinational instruction memory and captures the returned word into a 2-entry fetch queue. It hands {PC, INST} pairs to decode with a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts branch/jump redirects from execute.

---
 rtl/inst_fetch_ctrl_if.sv | 23 ++
 rtl/inst_fetch_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory port, decode handshake, redirect
// request from execute, and the halt status flag.
interface inst_fetch_ctrl_if;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    modport master (
        output addr, if_valid, if_pc, if_inst, halted,
        input  inst, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  addr, if_valid, if_pc, if_inst, halted,
        output inst, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a zero-latency memory and
// buffers {pc, inst} pairs in a 2-entry queue feeding decode.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_ctrl_if.master bus
);
    localparam logic [1:0] DEPTH = 2'(QDEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [31:0] q_pc   [2];
    logic [31:0] q_inst [2];
    logic        pop, push, eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        eop       = 1'b0;
        pop       = (count != 2'd0) & bus.id_ready;
        if (state == FETCH && !bus.redirect) begin
            if (bus.inst == 32'h0) eop  = 1'b1;
            else                   push = (count < DEPTH) | pop;
        end
        if (bus.redirect) state_nxt = FETCH;
        else if (eop)     state_nxt = HALT;
    end

    // Redirect flushes the queue, including any pop offered in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]   <= 32'h0;
                q_inst[i] <= 32'h0;
            end
        end else if (bus.redirect) begin
            pc     <= bus.redirect_pc & ~32'd3;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]   <= pc;
                q_inst[wr_ptr] <= bus.inst;
                wr_ptr         <= ~wr_ptr;
                pc             <= pc + 32'd4;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.addr     = pc;
    assign bus.if_valid = (count != 2'd0);
    assign bus.if_pc    = q_pc[rd_ptr];
    assign bus.if_inst  = q_inst[rd_ptr];
    assign bus.halted   = (state == HALT);
endmodule
